// File: rtl/da_lut_accumulator.sv
// Distributed-arithmetic engine: writable multi-row partial-sum LUT
// feeding an MSB-first bit-serial shift-accumulate datapath.
module da_lut_accumulator #(
    parameter int COEF_W    = 16,
    parameter int DATA_BITS = 8,
    parameter int ADDR_W    = 4,
    parameter int ROW_W     = 3,
    parameter int ACC_W     = COEF_W + DATA_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [ROW_W+ADDR_W-1:0] cfg_addr,
    input  logic [COEF_W-1:0]       cfg_data,
    input  logic                    start,
    input  logic [ROW_W-1:0]        row,
    input  logic                    slice_valid,
    input  logic [ADDR_W-1:0]       slice_addr,
    output logic                    busy,
    output logic [ACC_W-1:0]        dout,
    output logic                    dout_valid
);

    localparam int N_ENT = 2 ** (ROW_W + ADDR_W);
    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t              state_q, state_d;
    logic [COEF_W-1:0]   lut_q [N_ENT];
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    dout_q, dout_d;
    logic                dv_q, dv_d;

    logic                lut_we;
    logic                accept;
    logic                last;
    logic [COEF_W-1:0]   rd;
    logic [ACC_W-1:0]    rd_ext;

    assign lut_we = cfg_we && (state_q == IDLE);
    assign accept = slice_valid && (state_q == ACCUM);
    assign last   = (cnt_q == LAST);
    assign rd     = lut_q[{row_q, slice_addr}];
    assign rd_ext = {{(ACC_W-COEF_W){rd[COEF_W-1]}}, rd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (accept && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ACCUM);
    end

    // The sign slice carries negative weight, hence the subtraction.
    always_comb begin
        row_d  = row_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        if ((state_q == IDLE) && start) begin
            row_d = row;
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (cnt_q == '0) begin
                acc_d = -rd_ext;
            end else begin
                acc_d = (acc_q << 1) + rd_ext;
            end
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                dout_d = acc_d;
                dv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            row_q  <= row_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[cfg_addr] <= cfg_data;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;

endmodule
